// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into instruction words and queues {word, addr, err} in a small FIFO.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int DEPTH     = 2,
  parameter int ADDR_STEP = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [31:0]              base_addr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               opcode,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [31:0]              immediate,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_addr,
  output logic                     out_err,
  output logic                     err_sticky,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  function automatic logic rng_bad(input logic signed [31:0] v, input logic signed [31:0] lo,
                                   input logic signed [31:0] hi, input logic even);
    return (v < lo) || (v > hi) || (even && v[0]);
  endfunction

  // Returns {err, word}; illegal opcodes become a NOP flagged as an error.
  function automatic logic [32:0] encode(input logic [6:0] op, input logic [4:0] d,
                                         input logic [4:0] s1, input logic [4:0] s2,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic signed [31:0] imm);
    logic [31:0] w;
    logic        e;
    w = 32'h0000_0013;
    e = 1'b1;
    case (op)
      OP_R: begin
        w = {f7, s2, s1, f3, d, op};
        e = 1'b0;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        w = {imm[11:0], s1, f3, d, op};
        e = RANGE_EN && rng_bad(imm, -32'sd2048, 32'sd2047, 1'b0);
      end
      OP_STORE: begin
        w = {imm[11:5], s2, s1, f3, imm[4:0], op};
        e = RANGE_EN && rng_bad(imm, -32'sd2048, 32'sd2047, 1'b0);
      end
      OP_BR: begin
        w = {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], op};
        e = RANGE_EN && rng_bad(imm, -32'sd4096, 32'sd4094, 1'b1);
      end
      OP_LUI, OP_AUIPC: begin
        w = {imm[31:12], d, op};
        e = RANGE_EN && (imm[11:0] != 12'd0);
      end
      OP_JAL: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], d, op};
        e = RANGE_EN && rng_bad(imm, -32'sd1048576, 32'sd1048574, 1'b1);
      end
      default: ;
    endcase
    return {e, w};
  endfunction

  logic [32:0]   enc_p0;
  logic [31:0]   instr_p1 [DEPTH];
  logic [31:0]   addr_p1  [DEPTH];
  logic          err_p1   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   addr_cnt;
  logic          push, pop;

  // Stage p0: combinational packing of the presented field bundle.
  assign enc_p0 = encode(opcode, rd, rs1, rs2, funct3, funct7, $signed(immediate));

  // DEPTH is a power of two, so the count MSB alone marks a full FIFO.
  assign in_ready  = !count[AW] && !start;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      addr_cnt   <= '0;
      err_sticky <= 1'b0;
    end else if (start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      addr_cnt   <= base_addr;
      err_sticky <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_ONE;
        addr_cnt   <= addr_cnt + 32'(ADDR_STEP);
        err_sticky <= err_sticky | enc_p0[32];
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Stage p1: FIFO storage, written on push only.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_p1[wr_ptr] <= enc_p0[31:0];
      addr_p1[wr_ptr]  <= addr_cnt;
      err_p1[wr_ptr]   <= enc_p0[32];
    end
  end

  assign out_instr = out_valid ? instr_p1[rd_ptr] : '0;
  assign out_addr  = out_valid ? addr_p1[rd_ptr]  : '0;
  assign out_err   = out_valid && err_p1[rd_ptr];
  assign level     = count;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: accepts decoded instruction fields on a valid/ready input, packs them into a 32-bit instruction word according to the format implied by the opcode, and delivers word, address and error flag through a small output FIFO. It sits on the instruction-memory loader and self-test path. It is the inverse of the instruction-decode stage, so decode(encode(fields)) round-trips in verification.

## Interface
- DEPTH, 2: output FIFO entries; power of two, at least 2.
- ADDR_STEP, 4: byte increment of `out_addr` per accepted instruction.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  loads `base_addr` into the address counter, flushes the FIFO, clears `err_sticky`.
- base_addr  in  32  starting address for the program.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  `count < DEPTH && !start`.
- opcode  in  7  opcode field; selects the format.
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3 / funct7  in  7  function fields.
- immediate  in  32  sign-extended byte offset or value.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry.
- out_instr  out  32  encoded word.
- out_addr  out  32  address of `out_instr`.
- out_err  out  1  the head word is illegal or range-violating.
- err_sticky  out  1  OR of all `out_err` values pushed since reset/start.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Format by opcode:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
- Packing follows the RV32I base spec:
  - R: funct7|rs2|rs1|funct3|rd|op.
  - I: imm[11:0]|rs1|funct3|rd|op.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Fields unused by a format are ignored.
- Any other opcode: word = 0x00000013 (NOP), err = 1.
- Push occurs on `in_valid && in_ready`. The entry is {word, addr_cnt, err}, and `addr_cnt += ADDR_STEP` wraps modulo 2^32.
- Pop occurs on `out_valid && out_ready`.
- Simultaneous push and pop leave `level` unchanged. In-order delivery is guaranteed.
- `start` has priority over push and pop in the same cycle. That cycle's input is not accepted and no pop occurs.

## Timing
- Reset values: `out_valid` = 0, `level` = 0, `out_instr`/`out_addr`/`out_err` = 0, `err_sticky` = 0, address counter = 0, `in_ready` = 1.
- Latency: a word accepted at edge N is visible at the head after edge N if the FIFO was empty. There is no combinational in-to-out path.
- `in_ready` depends only on registered state and `start`, never on `out_ready`. A full FIFO accepts nothing even while popping.
- Full throughput with `level` = 1 and continuous push/pop: one word per cycle.
- Async reset mid-stream discards all entries immediately.
- Output fields are held stable while `out_valid && !out_ready`.

## Configuration
- `ENC_RANGE_CHECK_EN` defined: set err = 1 (word still emitted, truncated to the field bits) when any of the following holds:
  - I/S imm outside [-2048, 2047].
  - B imm outside [-4096, 4094] or odd.
  - J imm outside [-2^20, 2^20-2] or odd.
  - U imm[11:0] != 0.
- Undefined: no range checks. err = 1 only for an illegal opcode, and imm bits are silently truncated.

## Test plan
- Reset then start with `base_addr` = 0x100. Push ADD x3,x1,x2 (op 0110011, f3 0, f7 0) → `out_instr` 0x002081B3, `out_addr` 0x100, err 0.
- Back-to-back pushes, always ready:
  - ADDI x1,x0,-1 → 0xFFF00093.
  - SW x2,8(x1) → 0x0020A423.
  - BEQ x1,x2,-4 → 0xFE208EE3.
  - JAL x1,+2048 → 0x001000EF.
  - LUI x5,0x12345000 → 0x123452B7.
  - Addresses step by 4, one word per cycle.
- `out_ready` = 0, push 3 words with DEPTH = 2 → `in_ready` drops after 2 pushes and `level` = 2. Release → 3 words arrive in order with no loss or duplication.
- ADDI x1,x0,2048 → word 0x80000093. err 1 and `err_sticky` 1 with the macro; err 0 without it. Opcode 1111111 → 0x00000013, err 1 in both builds.
- Assert `start` with `level` = 2 and `in_valid` high → FIFO empty next cycle, input not accepted, `err_sticky` 0, next word gets the new `base_addr`.
- `rst_n` low mid-burst → all outputs are at reset values immediately (asynchronously), before the next clock edge.
